// File: rtl/ixc_osf_mb_sched_if.sv
// Requester/mailbox bundle for ixc_osf_mb_sched; master drives requests and the ack, slave is the scheduler.
interface ixc_osf_mb_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 20,
  parameter int TW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      mb_vec;
  logic               mb_ev;
  logic               mb_ack;
  logic [TW-1:0]      tmo_limit;
  logic               err_clr;
  logic               busy;
  logic               tmo_err;

  modport master (
    output req, req_data, mb_ack, tmo_limit, err_clr,
    input  gnt, mb_vec, mb_ev, busy, tmo_err
  );

  modport slave (
    input  req, req_data, mb_ack, tmo_limit, err_clr,
    output gnt, mb_vec, mb_ev, busy, tmo_err
  );
endinterface

// File: rtl/ixc_osf_mb_sched.sv
// Round-robin scheduler posting one requester vector at a time to the OSF mailbox; gnt/mb_ev one cycle after req.
// Requests are held off while busy; defining IXC_OSF_SCHED_TMO_EN adds an ack timeout with a sticky tmo_err.
module ixc_osf_mb_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 20,
  parameter int TW   = 8
) (
  input logic               clk,
  input logic               rst_n,
  ixc_osf_mb_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_POST, S_WAIT} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [DW-1:0]   r_mb_vec;
  logic            r_mb_ev;
  logic [IW-1:0]   r_last;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;
  logic            w_tmo;

  // Scan upward from the slot after the last winner, wrapping once around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

`ifdef IXC_OSF_SCHED_TMO_EN
  logic [TW-1:0] r_cnt;
  logic          r_tmo_err;

  // Fires in WAIT cycle max(tmo_limit,1); an ack arriving in that same cycle takes precedence.
  assign w_tmo = (r_state == S_WAIT) && !bus.mb_ack &&
                 (({1'b0, r_cnt} + 1'b1) >= {1'b0, bus.tmo_limit});
  assign bus.tmo_err = r_tmo_err;
`else
  logic w_unused;
  assign w_unused    = ^{bus.tmo_limit, bus.err_clr};
  assign w_tmo       = 1'b0;
  assign bus.tmo_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_mb_ev  <= 1'b0;
      r_mb_vec <= '0;
      r_last   <= IW'(NREQ - 1);
`ifdef IXC_OSF_SCHED_TMO_EN
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
`endif
    end else begin
      r_gnt   <= '0;
      r_mb_ev <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_POST;
            r_gnt    <= NREQ'(1) << w_win;
            r_mb_ev  <= 1'b1;
            r_mb_vec <= bus.req_data[int'(w_win)*DW +: DW];
            r_last   <= w_win;
          end
        end
        S_POST: r_state <= bus.mb_ack ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (bus.mb_ack || w_tmo) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef IXC_OSF_SCHED_TMO_EN
      if (r_state == S_POST) r_cnt <= '0;
      else if (r_state == S_WAIT && !bus.mb_ack) r_cnt <= r_cnt + 1'b1;
      if (w_tmo) r_tmo_err <= 1'b1;
      else if (bus.err_clr) r_tmo_err <= 1'b0;
`endif
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.mb_ev  = r_mb_ev;
  assign bus.mb_vec = r_mb_vec;
  assign bus.busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_ixc_osf_mb_sched.sv
// Bench for ixc_osf_mb_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_ixc_osf_mb_sched;
  localparam int NREQ = 4;
  localparam int DW   = 20;
  localparam int TW   = 8;

`ifdef IXC_OSF_SCHED_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  ixc_osf_mb_sched_if #(.NREQ(NREQ), .DW(DW), .TW(TW)) bus ();

  ixc_osf_mb_sched #(.NREQ(NREQ), .DW(DW), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int              n_chk = 0;
  int              n_fail = 0;
  int              cyc_n = 0;
  logic [NREQ-1:0] pend;
  logic [DW-1:0]   pdata [NREQ];
  int              m_last;
  logic [DW-1:0]   m_vec;
  bit              m_err;
  int              m_lim;
  bit              rnd_mode;
  logic [NREQ-1:0] obs_gnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Round-robin rule: first requester found scanning upward from last+1, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drive_req();
    bus.req = pend;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = pdata[i];
  endtask

  task automatic add_random();
    logic [NREQ-1:0] nb;
    nb = NREQ'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      if (nb[i] && !pend[i]) pdata[i] = DW'($urandom);
    end
    pend = pend | nb;
    drive_req();
  endtask

  task automatic quiet(input string tag, input bit busy_exp);
    check_eq({tag, "_gnt"},  32'(bus.gnt), 32'(0));
    check_eq({tag, "_ev"},   32'(bus.mb_ev), 32'(0));
    check_eq({tag, "_vec"},  32'(bus.mb_vec), 32'(m_vec));
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'(busy_exp));
    check_eq({tag, "_err"},  32'(bus.tmo_err), 32'(m_err));
  endtask

  // One full post: grant the model's winner, then ack after ack_dly cycles (ack_dly<0 means never).
  task automatic txn(input int ack_dly, input bit clr_end);
    int w;
    int n;
    int e;
    bit to;
    w = pick(pend, m_last);
    step();
    m_vec   = pdata[w];
    m_last  = w;
    obs_gnt = bus.gnt;
    check_eq("gnt",       32'(bus.gnt), 32'(1) << w);
    check_eq("mb_ev",     32'(bus.mb_ev), 32'(1));
    check_eq("mb_vec",    32'(bus.mb_vec), 32'(m_vec));
    check_eq("busy_post", 32'(bus.busy), 32'(1));
    pend[w] = 1'b0;
    drive_req();
    n  = (m_lim == 0) ? 1 : m_lim;
    to = TMO_EN && (ack_dly < 0 || ack_dly > n);
    e  = to ? n : ack_dly;
    for (int c = 0; c <= e; c++) begin
      bus.mb_ack  = (c == ack_dly);
      bus.err_clr = clr_end && (c == e);
      if (rnd_mode && c == 1 && $urandom_range(0, 3) == 0) add_random();
      step();
      if (c < e) quiet("wait", 1'b1);
    end
    bus.mb_ack  = 1'b0;
    bus.err_clr = 1'b0;
    if (to) m_err = 1'b1;
    else if (clr_end) m_err = 1'b0;
    quiet("done", 1'b0);
  endtask

  task automatic idle_cycle(input bit ack, input bit clr);
    bus.mb_ack  = ack;
    bus.err_clr = clr;
    step();
    bus.mb_ack  = 1'b0;
    bus.err_clr = 1'b0;
    if (clr) m_err = 1'b0;
    quiet("idle", 1'b0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    m_last = NREQ - 1;
    m_vec  = '0;
    m_err  = 1'b0;
    pend   = '0;
    drive_req();
    bus.mb_ack  = 1'b0;
    bus.err_clr = 1'b0;
    quiet("rst", 1'b0);
    step();
    quiet("rst_hold", 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d cycles elapsed", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.mb_ack    = 1'b0;
    bus.err_clr   = 1'b0;
    m_lim         = 200;
    bus.tmo_limit = TW'(m_lim);
    rnd_mode      = 1'b0;
    pend          = '0;
    for (int i = 0; i < NREQ; i++) pdata[i] = '0;
    @(negedge clk);
    reset_dut();

    // Single post, ack two cycles after mb_ev.
    pdata[0] = 20'h12345;
    pend     = 4'b0001;
    drive_req();
    txn(2, 1'b0);
    check_eq("single_gnt", 32'(obs_gnt), 32'h1);

    // Reset while waiting for the ack abandons the post.
    pend     = 4'b0001;
    pdata[0] = DW'($urandom);
    drive_req();
    step();
    check_eq("pre_rst_gnt", 32'(bus.gnt), 32'h1);
    pend = '0;
    drive_req();
    step();
    step();
    check_eq("pre_rst_busy", 32'(bus.busy), 32'h1);
    reset_dut();
    idle_cycle(1'b0, 1'b0);
    pend     = 4'b0010;
    pdata[1] = DW'($urandom);
    drive_req();
    txn(0, 1'b0);
    check_eq("post_rst_gnt", 32'(obs_gnt), 32'h2);

    // All four requesting from reset: strict 0,1,2,3 rotation.
    reset_dut();
    pend = '1;
    for (int i = 0; i < NREQ; i++) pdata[i] = DW'($urandom);
    drive_req();
    for (int k = 0; k < NREQ; k++) begin
      txn(0, 1'b0);
      check_eq("rr_order", 32'(obs_gnt), 32'(1) << k);
    end

    // Last winner 3: requester 0 wins by wrap-around, then 3.
    pend     = 4'b1001;
    pdata[0] = DW'($urandom);
    pdata[3] = DW'($urandom);
    drive_req();
    txn(0, 1'b0);
    check_eq("wrap_first", 32'(obs_gnt), 32'h1);
    txn(0, 1'b0);
    check_eq("wrap_second", 32'(obs_gnt), 32'h8);

    // Random traffic.
    rnd_mode = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) != 0) add_random();
      if (TMO_EN) begin
        m_lim         = int'($urandom_range(0, 6));
        bus.tmo_limit = TW'(m_lim);
      end
      if (pend == '0) idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (TMO_EN) txn(int'($urandom_range(0, 9)) - 1, 1'($urandom_range(0, 1)));
      else txn(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end
    rnd_mode      = 1'b0;
    m_lim         = 200;
    bus.tmo_limit = TW'(m_lim);
    for (int i = 0; i < NREQ; i++) begin
      if (pend != '0) txn(0, 1'b0);
    end

`ifdef IXC_OSF_SCHED_TMO_EN
    idle_cycle(1'b0, 1'b1);
    m_lim         = 3;
    bus.tmo_limit = TW'(m_lim);
    pend          = 4'b0001;
    pdata[0]      = DW'($urandom);
    drive_req();
    txn(-1, 1'b0);
    check_eq("tmo_err_set", 32'(bus.tmo_err), 32'h1);
    idle_cycle(1'b0, 1'b1);
    check_eq("tmo_err_clr", 32'(bus.tmo_err), 32'h0);
    pend     = 4'b0100;
    pdata[2] = DW'($urandom);
    drive_req();
    txn(-1, 1'b1);
    check_eq("tmo_clr_vs_set", 32'(bus.tmo_err), 32'h1);
    idle_cycle(1'b0, 1'b1);
    m_lim         = 0;
    bus.tmo_limit = TW'(m_lim);
    pend          = 4'b1000;
    pdata[3]      = DW'($urandom);
    drive_req();
    txn(-1, 1'b0);
    check_eq("tmo_limit0", 32'(bus.tmo_err), 32'h1);
    idle_cycle(1'b0, 1'b1);
    m_lim         = 2;
    bus.tmo_limit = TW'(m_lim);
    pend          = 4'b0010;
    pdata[1]      = DW'($urandom);
    drive_req();
    txn(2, 1'b0);
    check_eq("ack_at_limit", 32'(bus.tmo_err), 32'h0);
`else
    pend     = 4'b0100;
    pdata[2] = DW'($urandom);
    drive_req();
    txn(1000, 1'b0);
    check_eq("no_tmo_err", 32'(bus.tmo_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
